// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the little-computer multi-port register file.
// Defaults track the RegWidth/NumRegs values in defs.vh.
package regfile_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_NUM_REGS = 8;
   localparam int DEF_AW       = $clog2(DEF_NUM_REGS);
   localparam int DEF_NUM_READ = 2;

   // Read port i occupies rd_addr[i*RD_SLICE +: RD_SLICE] at default sizing.
   localparam int RD_SLICE     = DEF_AW;

   // popcount works on a fixed-width vector; callers zero-extend (NUM_REGS <= MAX_REGS).
   localparam int MAX_REGS     = 64;
   localparam int CNT_W        = 7;

   function automatic logic [CNT_W-1:0] popcount(input logic [MAX_REGS-1:0] bits);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < MAX_REGS; i++) begin
         n = n + CNT_W'(bits[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: stored-value select, write-first forwarding,
// pending/busy reporting and optional r0 masking.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int AW       = $clog2(NUM_REGS),
   parameter int ZERO_REG = 0
) (
   input  logic [AW-1:0]             rd_addr,
   input  logic [NUM_REGS*WIDTH-1:0] reg_state,
   input  logic [NUM_REGS-1:0]       pending,
   input  logic                      wr_en,
   input  logic [AW-1:0]             wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      ld_en,
   input  logic [AW-1:0]             ld_addr,
   input  logic [WIDTH-1:0]          ld_data,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      rd_busy
);

   logic [WIDTH-1:0] stored;
   logic             wr_fwd;
   logic             ld_fwd;

   always_comb begin
      stored = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (rd_addr == AW'(r)) stored = reg_state[r*WIDTH +: WIDTH];
      end

      wr_fwd = wr_en && (wr_addr == rd_addr);
      ld_fwd = ld_en && (ld_addr == rd_addr);

      // ALU result is younger than a returning load, so it wins the forward.
      if (wr_fwd)      rd_data = wr_data;
      else if (ld_fwd) rd_data = ld_data;
      else             rd_data = stored;

      rd_busy = pending[rd_addr] & ~ld_fwd;

      if (ZERO_REG != 0 && rd_addr == '0) begin
         rd_data = '0;
         rd_busy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: N forwarding read ports, ALU and load-return write
// ports, and a per-register pending scoreboard for outstanding loads.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int AW       = $clog2(NUM_REGS),
   parameter int NUM_READ = DEF_NUM_READ,
   parameter int ZERO_REG = 0
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NUM_READ*AW-1:0]    rd_addr,
   input  logic [NUM_READ-1:0]       rd_used,
   output logic [NUM_READ*WIDTH-1:0] rd_data,
   output logic [NUM_READ-1:0]       rd_busy,
   output logic                      hazard,
   input  logic                      wr_en,
   input  logic [AW-1:0]             wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      rsv_en,
   input  logic [AW-1:0]             rsv_addr,
   input  logic                      ld_en,
   input  logic [AW-1:0]             ld_addr,
   input  logic [WIDTH-1:0]          ld_data,
   output logic [NUM_REGS*WIDTH-1:0] reg_state,
   output logic [NUM_REGS-1:0]       pending,
   output logic [AW:0]               pending_cnt,
   output logic                      err
);

   localparam int CW = AW + 1;

   logic [WIDTH-1:0]    regs [NUM_REGS];
   logic [NUM_REGS-1:0] wr_hit;
   logic [NUM_REGS-1:0] ld_hit;
   logic [NUM_REGS-1:0] rsv_hit;
   logic [NUM_REGS-1:0] pending_next;
   logic                proto_err;

   // Protocol: rsv marks a register as owed by a load; the matching ld returns
   // the data and clears it. Any other ordering is flagged on err.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         wr_hit[r]  = wr_en  && (wr_addr  == AW'(r));
         ld_hit[r]  = ld_en  && (ld_addr  == AW'(r));
         rsv_hit[r] = rsv_en && (rsv_addr == AW'(r));
      end
      if (ZERO_REG != 0) begin
         wr_hit[0]  = 1'b0;
         ld_hit[0]  = 1'b0;
         rsv_hit[0] = 1'b0;
      end

      pending_next = (pending & ~ld_hit) | rsv_hit;

      proto_err = (|(wr_hit  & pending & ~ld_hit)) |
                  (|(ld_hit  & ~pending))          |
                  (|(rsv_hit & pending & ~ld_hit));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
         pending     <= '0;
         pending_cnt <= '0;
         err         <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (wr_hit[r])      regs[r] <= wr_data;
            else if (ld_hit[r]) regs[r] <= ld_data;
         end
         pending     <= pending_next;
         pending_cnt <= CW'(popcount(MAX_REGS'(pending_next)));
         if (proto_err) err <= 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_state
      assign reg_state[g*WIDTH +: WIDTH] = regs[g];
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      regfile_read_port #(
         .WIDTH    (WIDTH),
         .NUM_REGS (NUM_REGS),
         .AW       (AW),
         .ZERO_REG (ZERO_REG)
      ) u_rd (
         .rd_addr   (rd_addr[i*AW +: AW]),
         .reg_state (reg_state),
         .pending   (pending),
         .wr_en     (wr_en),
         .wr_addr   (wr_addr),
         .wr_data   (wr_data),
         .ld_en     (ld_en),
         .ld_addr   (ld_addr),
         .ld_data   (ld_data),
         .rd_data   (rd_data[i*WIDTH +: WIDTH]),
         .rd_busy   (rd_busy[i])
      );
   end

   assign hazard = |(rd_used & rd_busy);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one ordinary-r0 instance and one ZERO_REG=1
// instance driven by the same stimulus, checked with immediate assertions.
module tb_regfile_mp;

   localparam int W  = 16;
   localparam int NR = 8;
   localparam int AW = 3;
   localparam int NP = 2;

   logic            CLK = 1'b0;
   logic            RST;
   logic [NP*AW-1:0] rd_addr;
   logic [NP-1:0]   rd_used;
   logic            wr_en, rsv_en, ld_en;
   logic [AW-1:0]   wr_addr, rsv_addr, ld_addr;
   logic [W-1:0]    wr_data, ld_data;

   logic [NP*W-1:0] rd_data,   rd_data_z;
   logic [NP-1:0]   rd_busy,   rd_busy_z;
   logic            hazard,    hazard_z;
   logic [NR*W-1:0] reg_state, reg_state_z;
   logic [NR-1:0]   pending,   pending_z;
   logic [AW:0]     pending_cnt, pending_cnt_z;
   logic            err,       err_z;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   regfile_mp #(.WIDTH(W), .NUM_REGS(NR), .NUM_READ(NP), .ZERO_REG(0)) u_dut (
      .CLK(CLK), .RST(RST), .rd_addr(rd_addr), .rd_used(rd_used),
      .rd_data(rd_data), .rd_busy(rd_busy), .hazard(hazard),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .reg_state(reg_state), .pending(pending), .pending_cnt(pending_cnt), .err(err)
   );

   regfile_mp #(.WIDTH(W), .NUM_REGS(NR), .NUM_READ(NP), .ZERO_REG(1)) u_dut_z (
      .CLK(CLK), .RST(RST), .rd_addr(rd_addr), .rd_used(rd_used),
      .rd_data(rd_data_z), .rd_busy(rd_busy_z), .hazard(hazard_z),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .reg_state(reg_state_z), .pending(pending_z), .pending_cnt(pending_cnt_z), .err(err_z)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; rsv_en = 1'b0; ld_en = 1'b0; rd_used = '0;
   endtask

   function automatic logic [W-1:0] reg_of(input logic [NR*W-1:0] st, input int r);
      return st[r*W +: W];
   endfunction

   initial begin
      RST = 1'b1;
      rd_addr = '0; rd_used = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rsv_en = 1'b0; rsv_addr = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      tick(); tick();
      RST = 1'b0;
      #1;

      // Reset state and full address sweep on both ports
      chk("rst_pending_cnt", pending_cnt, 0);
      chk("rst_err", err, 0);
      chk("rst_pending", pending, 0);
      for (int a = 0; a < NR; a++) begin
         rd_addr = {AW'(a), AW'(a)};
         #1;
         chk("rst_rd_data", rd_data, 0);
         chk("rst_rd_busy", rd_busy, 0);
      end

      // Write gating on r0
      rd_addr = {3'd1, 3'd0};
      wr_addr = 3'd0; wr_data = 16'h0001; wr_en = 1'b0;
      tick();
      chk("gate_off_r0", rd_data[15:0], 16'h0000);
      chk("gate_off_state", reg_state, 0);
      wr_en = 1'b1;
      #1;
      chk("z_r0_fwd_masked", rd_data_z[15:0], 16'h0000);
      tick();
      wr_en = 1'b0;
      #1;
      chk("gate_on_r0", rd_data[15:0], 16'h0001);
      chk("gate_on_r1", rd_data[31:16], 16'h0000);
      chk("gate_on_state_r0", reg_of(reg_state, 0), 16'h0001);
      chk("z_state_r0", reg_of(reg_state_z, 0), 16'h0000);
      chk("z_rd_r0", rd_data_z[15:0], 16'h0000);

      // Combinational forwarding on port 1
      rd_addr = {3'd3, 3'd0};
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
      #1;
      chk("fwd_wr_port1", rd_data[31:16], 16'hBEEF);
      chk("fwd_state_unchanged", reg_of(reg_state, 3), 16'h0000);
      tick();
      wr_en = 1'b0;
      #1;
      chk("fwd_stored", reg_of(reg_state, 3), 16'hBEEF);

      // Same-cycle wr and ld to r3: ALU data wins
      rsv_en = 1'b1; rsv_addr = 3'd3;
      tick();
      rsv_en = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1111;
      ld_en = 1'b1; ld_addr = 3'd3; ld_data = 16'h2222;
      #1;
      chk("wrld_fwd", rd_data[31:16], 16'h1111);
      tick();
      idle_inputs();
      #1;
      chk("wrld_stored", reg_of(reg_state, 3), 16'h1111);
      chk("wrld_pending", pending, 0);
      chk("wrld_err", err, 0);

      // Scoreboard: reserve r5, hazard, load return
      rsv_en = 1'b1; rsv_addr = 3'd5;
      tick();
      rsv_en = 1'b0;
      #1;
      chk("rsv5_pending", pending, 8'b0010_0000);
      chk("rsv5_cnt", pending_cnt, 1);
      rd_addr = {3'd1, 3'd5}; rd_used = 2'b01;
      #1;
      chk("rsv5_busy", rd_busy, 2'b01);
      chk("rsv5_hazard", hazard, 1);
      rd_used = 2'b10;
      #1;
      chk("rsv5_no_hazard_unused", hazard, 0);
      rd_used = 2'b01;
      tick();
      ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'h00AA;
      #1;
      chk("ld5_busy", rd_busy, 2'b00);
      chk("ld5_fwd", rd_data[15:0], 16'h00AA);
      chk("ld5_hazard", hazard, 0);
      tick();
      idle_inputs();
      #1;
      chk("ld5_cnt", pending_cnt, 0);
      chk("ld5_stored", reg_of(reg_state, 5), 16'h00AA);
      chk("ld5_err", err, 0);

      // Reserve and load on the same register in one cycle: stays pending
      rsv_en = 1'b1; rsv_addr = 3'd5;
      tick();
      ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'h0055;
      tick();
      idle_inputs();
      #1;
      chk("rsvld_pending", pending, 8'b0010_0000);
      chk("rsvld_cnt", pending_cnt, 1);
      chk("rsvld_data", reg_of(reg_state, 5), 16'h0055);
      chk("rsvld_err", err, 0);
      ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'h0077;
      tick();
      idle_inputs();
      #1;
      chk("rsvld_clear_cnt", pending_cnt, 0);

      // Load to non-pending r2 sets sticky err
      ld_en = 1'b1; ld_addr = 3'd2; ld_data = 16'h0202;
      tick();
      idle_inputs();
      #1;
      chk("ldnp_err", err, 1);
      chk("ldnp_stored", reg_of(reg_state, 2), 16'h0202);
      repeat (10) tick();
      chk("ldnp_err_sticky", err, 1);
      #2;
      RST = 1'b1;
      #1;
      chk("rst_clears_err", err, 0);
      chk("rst_clears_regs", reg_state, 0);
      tick();
      RST = 1'b0;

      // WAW with an outstanding load
      rsv_en = 1'b1; rsv_addr = 3'd4;
      tick();
      rsv_en = 1'b0;
      #1;
      chk("waw_no_err_yet", err, 0);
      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444;
      tick();
      idle_inputs();
      #1;
      chk("waw_err", err, 1);
      chk("waw_data", reg_of(reg_state, 4), 16'h4444);
      chk("waw_pending", pending, 8'b0001_0000);

      // r0 reservations ignored when hardwired
      RST = 1'b1;
      tick();
      RST = 1'b0;
      rsv_en = 1'b1; rsv_addr = 3'd0;
      tick();
      rsv_en = 1'b0;
      #1;
      chk("z_rsv0_pending", pending_z, 0);
      chk("z_rsv0_err", err_z, 0);
      chk("rsv0_pending", pending, 8'b0000_0001);
      ld_en = 1'b1; ld_addr = 3'd0; ld_data = 16'hA0A0;
      tick();
      idle_inputs();
      #1;
      chk("z_ld0_err", err_z, 0);
      chk("z_ld0_state", reg_of(reg_state_z, 0), 16'h0000);
      chk("ld0_state", reg_of(reg_state, 0), 16'hA0A0);
      chk("ld0_err", err, 0);

      // Async reset mid-operation
      rsv_en = 1'b1; rsv_addr = 3'd6;
      tick();
      rsv_addr = 3'd7;
      tick();
      rsv_en = 1'b0;
      #1;
      chk("mid_cnt_before", pending_cnt, 2);
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1234;
      rsv_en = 1'b1; rsv_addr = 3'd2;
      #2;
      RST = 1'b1;
      #1;
      chk("mid_pending", pending, 0);
      chk("mid_cnt", pending_cnt, 0);
      chk("mid_regs", reg_state, 0);
      tick();
      chk("mid_regs_held", reg_state, 0);
      chk("mid_pending_held", pending, 0);
      idle_inputs();
      RST = 1'b0;
      tick();
      chk("post_rst_err", err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the little-computer core.
- Supports N combinational read ports with write-first forwarding and two write ports: the in-order ALU port and a late load-return port.
- Keeps a per-register pending scoreboard for long-latency loads, with busy/hazard flags and a sticky protocol-error flag.
- Sits between decode (read) and writeback/memory (write); exports full state for debug/test.

Parameters:
- WIDTH, 16, bits per register (matches RegWidth).
- NUM_REGS, 8, register count, power of two (matches NumRegs).
- AW, $clog2(NUM_REGS), address width (derived, not overridden).
- NUM_READ, 2, read ports, 1..4.
- ZERO_REG, 0:
  - 1 = r0 hardwired to zero.
  - 0 = r0 is an ordinary register.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- rd_addr  in  NUM_READ*AW  read addresses, port i at [i*AW +: AW].
- rd_used  in  NUM_READ  port i operand actually consumed this cycle.
- rd_data  out  NUM_READ*WIDTH  read values.
- rd_busy  out  NUM_READ  port i addresses a pending register.
- hazard  out  1  OR over i of (rd_used[i] & rd_busy[i]); decode stalls on it.
- wr_en, wr_addr, wr_data  in  1, AW, WIDTH  ALU write port.
- rsv_en, rsv_addr  in  1, AW  reserve register for an outstanding load.
- ld_en, ld_addr, ld_data  in  1, AW, WIDTH  load-return write; clears pending.
- reg_state  out  NUM_REGS*WIDTH  all register contents.
- pending  out  NUM_REGS  scoreboard bits.
- pending_cnt  out  AW+1  number of set pending bits.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, any time, including mid-operation): all registers = 0, pending = 0, pending_cnt = 0, err = 0. Outputs reflect this immediately; no partial writes complete.
- Reads are combinational, with zero-cycle latency from rd_addr.
- Forwarding priority for each read port:
  - wr_en & wr_addr==a → wr_data.
  - else ld_en & ld_addr==a → ld_data.
  - else stored value.
- rd_busy[i] = pending[a] & ~(ld_en & ld_addr==a), so a returning load is forwarded without stall.
- Writes occur on the CLK rising edge.
- wr_en and ld_en to the same address in the same cycle: wr_data stored, since the ALU result is the younger result.
- Different addresses in the same cycle: both written.
- wr_en=0 and ld_en=0: no register changes, whatever values sit on the data buses.
- Scoreboard update per edge: pending_next[r] = (pending[r] & ~ld_hit[r]) | rsv_hit[r].
  - rsv in the same cycle as ld to the same register leaves it pending (new reservation wins); data is still written.
- err sets and stays 1 until RST on any of:
  - wr_en to a register pending and not cleared by a same-cycle ld (WAW with an outstanding load).
  - ld_en to a non-pending register.
  - rsv_en to a register pending and not cleared by a same-cycle ld.
- An erroneous operation still takes effect as described above; err only reports it.
- pending_cnt is registered and equals popcount(pending) at all times. It is updated alongside pending, not recomputed combinationally from a separate path.
- ZERO_REG=1, register 0:
  - never written;
  - never pending, so rsv/ld to r0 are ignored and do not set err;
  - reads return 0 even when forwarding.
  - reg_state[0] is always 0.
- Address wrap: none; all AW-bit addresses are valid.

Decomposition:
- Package regfile_pkg holds:
  - default WIDTH/NUM_REGS constants, aligned with the defs.vh values;
  - helper function popcount;
  - localparam for the per-port slice.
- One sub-module, regfile_read_port: address decode, forwarding mux, busy computation, ZERO_REG masking. It is instantiated NUM_READ times via generate.
- Storage, scoreboard, err and pending_cnt stay in regfile_mp.

Test Plan:
- Reset then sweep all addresses on all read ports → rd_data=0, rd_busy=0, pending_cnt=0, err=0.
- Write port gating:
  - wr_addr=0, wr_data=1, wr_en=0, one edge → rd_data(r0)=0.
  - wr_en=1, edge → r0=1, r1 still 0.
  - With ZERO_REG=1 the same sequence → r0 stays 0.
- Forwarding:
  - wr_en=1, wr_addr=3, wr_data=0xBEEF with port1 reading r3 before the edge → rd_data[1]=0xBEEF combinationally.
  - Simultaneous wr and ld to r3 (0x1111 vs 0x2222) → 0x1111 stored.
- Scoreboard:
  - rsv r5 → pending[5]=1, pending_cnt=1.
  - Read r5 with rd_used=1 → hazard=1.
  - ld r5=0x00AA in a later cycle → same-cycle rd_busy=0 and rd_data=0x00AA; after the edge pending_cnt=0.
- Errors:
  - ld to non-pending r2 → err=1 after the edge, r2 written.
  - err persists over 10 cycles of idle, then clears only on RST pulse.
  - Separately, rsv r4 then wr r4 → err=1.
- Async reset mid-operation: rsv r6, r7, then assert RST between edges → pending=0, pending_cnt=0, all regs 0 before the next CLK edge.
